// File: rtl/seq_detect_ctrl_if.sv
// Bundles the session controls, symbol stream, detector hookup and status of seq_detect_ctrl.
// The master side is the host/environment; the slave side is the controller.
interface seq_detect_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] window_len;
  logic [7:0]  hit_limit;
  logic [2:0]  sym_in;
  logic        sym_valid;
  logic        det_found;
  logic [2:0]  det_data;
  logic        det_rst_n;
  logic        busy;
  logic        done;
  logic [7:0]  hit_count;
  logic        timed_out;
  logic        limit_reached;

  modport master (
    output start, abort, window_len, hit_limit, sym_in, sym_valid, det_found,
    input  det_data, det_rst_n, busy, done, hit_count, timed_out, limit_reached
  );

  modport slave (
    input  start, abort, window_len, hit_limit, sym_in, sym_valid, det_found,
    output det_data, det_rst_n, busy, done, hit_count, timed_out, limit_reached
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Session controller around an external 8-symbol sequence detector: resets the detector,
// forwards a bounded window of symbols, counts hits and reports how the session ended.
//
// state | meaning
// IDLE  | waiting for start; results of the last session held
// CLEAR | one cycle detector reset, window counter loaded
// RUN   | symbols forwarded, hits counted, window counting down
// DONE  | one-cycle done pulse, detector held in reset
module seq_detect_ctrl (
  input logic clk,
  input logic reset,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] win_len_q;
  logic [15:0] win_cnt;
  logic [7:0]  hit_lim_q;
  logic [7:0]  hit_cnt;
  logic        timed_out_q;
  logic        limit_q;

  logic [7:0]  hit_inc;
  logic        run_hit;
  logic        last_run;
  logic        lim_hit;

  // A hit coinciding with abort is dropped, so abort is folded in here.
  always_comb begin
    hit_inc  = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
    run_hit  = (state == RUN) && bus.det_found && !bus.abort;
    last_run = (win_cnt == 16'd1);
    lim_hit  = run_hit && (hit_lim_q != 8'd0) && (hit_inc == hit_lim_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = CLEAR;
      CLEAR: begin
        if (bus.abort)               state_nxt = IDLE;
        else if (win_len_q == 16'd0) state_nxt = DONE;
        else                         state_nxt = RUN;
      end
      RUN: begin
        if (bus.abort)                state_nxt = IDLE;
        else if (lim_hit || last_run) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.det_rst_n = (state == RUN);
    bus.det_data  = 3'b111;
    // Filler 3'b111 is not part of the pattern, so an invalid cycle breaks any partial match.
    if (state == RUN && bus.sym_valid) bus.det_data = bus.sym_in;
    bus.hit_count     = hit_cnt;
    bus.timed_out     = timed_out_q;
    bus.limit_reached = limit_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      win_len_q   <= 16'd0;
      win_cnt     <= 16'd0;
      hit_lim_q   <= 8'd0;
      hit_cnt     <= 8'd0;
      timed_out_q <= 1'b0;
      limit_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            win_len_q   <= bus.window_len;
            hit_lim_q   <= bus.hit_limit;
            hit_cnt     <= 8'd0;
            timed_out_q <= 1'b0;
            limit_q     <= 1'b0;
          end
        end
        CLEAR: begin
          if (bus.abort) begin
            timed_out_q <= 1'b0;
            limit_q     <= 1'b0;
          end else begin
            win_cnt <= win_len_q;
            if (win_len_q == 16'd0) timed_out_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            timed_out_q <= 1'b0;
            limit_q     <= 1'b0;
          end else begin
            win_cnt <= win_cnt - 16'd1;
            if (run_hit)  hit_cnt     <= hit_inc;
            if (lim_hit)  limit_q     <= 1'b1;
            if (last_run) timed_out_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.abort) begin
            timed_out_q <= 1'b0;
            limit_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: models the attached detector, predicts every output from a
// session-level model each cycle, and pins directed sessions with literal expectations.
module tb_seq_detect_ctrl;

  localparam logic [23:0] SEQ_W = {3'b001, 3'b101, 3'b110, 3'b000,
                                   3'b110, 3'b110, 3'b011, 3'b101};

  logic clk;
  logic reset;
  seq_detect_ctrl_if bus();

  seq_detect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int run_total = 0;
  int done_total = 0;

  function automatic logic [2:0] pat(input int i);
    logic [23:0] w;
    w = SEQ_W;
    return w[23 - 3*i -: 3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Attached detector: sliding window of the last 7 symbols plus the current one.
  logic [2:0] hist [0:6];
  int hist_n = 0;

  always @(posedge clk) begin
    if (!bus.det_rst_n) hist_n <= 0;
    else begin
      for (int i = 0; i < 6; i++) hist[i] <= hist[i+1];
      hist[6] <= bus.det_data;
      if (hist_n < 7) hist_n <= hist_n + 1;
    end
  end

  always_comb begin
    logic m;
    m = bus.det_rst_n && (hist_n >= 7) && (bus.det_data == pat(7));
    for (int i = 0; i < 7; i++) if (hist[i] != pat(i)) m = 1'b0;
    bus.det_found = m;
  end

  // Session-level reference model.
  bit         m_act, m_clr, m_fin;
  int         m_w, m_l, m_left, m_hits;
  bit         m_to, m_lr;
  logic [2:0] fwd [$];

  task automatic model_reset();
    m_act = 0; m_clr = 0; m_fin = 0;
    m_w = 0; m_l = 0; m_left = 0; m_hits = 0;
    m_to = 0; m_lr = 0;
    fwd.delete();
  endtask

  task automatic model_step();
    logic [2:0] s;
    bit hit;
    if (!m_act) begin
      if (bus.start) begin
        m_act = 1; m_clr = 1; m_fin = 0;
        m_w = int'(bus.window_len); m_l = int'(bus.hit_limit);
        m_hits = 0; m_to = 0; m_lr = 0;
      end
    end else if (bus.abort) begin
      m_act = 0; m_to = 0; m_lr = 0;
    end else if (m_fin) begin
      m_act = 0;
    end else if (m_clr) begin
      m_clr = 0;
      fwd.delete();
      m_left = m_w;
      if (m_w == 0) begin m_fin = 1; m_to = 1; end
    end else begin
      s = bus.sym_valid ? bus.sym_in : 3'b111;
      fwd.push_back(s);
      if (fwd.size() > 8) void'(fwd.pop_front());
      hit = (fwd.size() == 8);
      for (int i = 0; i < fwd.size(); i++) if (fwd[i] != pat(i)) hit = 0;
      if (hit && m_hits < 255) m_hits++;
      m_left--;
      if (hit && m_l != 0 && m_hits == m_l) begin m_lr = 1; m_fin = 1; end
      if (m_left == 0) begin m_to = 1; m_fin = 1; end
    end
  endtask

  always @(negedge clk) begin
    bit e_busy, e_done, e_rstn;
    logic [2:0] e_data;
    if (reset) model_reset();
    e_busy = m_act;
    e_done = m_act && m_fin;
    e_rstn = m_act && !m_fin && !m_clr;
    e_data = (e_rstn && bus.sym_valid) ? bus.sym_in : 3'b111;
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("det_rst_n", bus.det_rst_n, e_rstn);
    chk("det_data", bus.det_data, e_data);
    chk("hit_count", bus.hit_count, m_hits);
    chk("timed_out", bus.timed_out, m_to);
    chk("limit_reached", bus.limit_reached, m_lr);
    if (bus.det_rst_n === 1'b1) run_total++;
    if (bus.done === 1'b1) done_total++;
    if (!reset) model_step();
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic session(input string tag, input int w, input int l, input int nsym,
                         input int gap_at, input int abort_at, input int rst_at,
                         input int start_at, input int e_hits, input int e_to,
                         input int e_lr, input int e_runs, input int e_done);
    int r0, d0, k, r;
    bit early;
    r0 = run_total; d0 = done_total; k = 0; r = 1; early = 0;
    bus.start = 1; bus.window_len = 16'(w); bus.hit_limit = 8'(l);
    bus.sym_valid = 0;
    step();
    bus.start = 0;
    step();
    while (bus.busy && r <= 300) begin
      bus.abort = (r == abort_at);
      bus.start = (r == start_at);
      if (gap_at > 0 && r == gap_at + 1) begin
        bus.sym_valid = 0;
        bus.sym_in = 3'(r);
        #2 chk({tag, "_gap_data"}, bus.det_data, 3'b111);
      end else if (k < nsym) begin
        bus.sym_valid = 1; bus.sym_in = pat(k % 8); k++;
      end else begin
        bus.sym_valid = 0; bus.sym_in = 3'(r);
      end
      if (r == rst_at) begin
        #1 reset = 1;
        #1;
        chk({tag, "_async_busy"}, bus.busy, 0);
        chk({tag, "_async_rstn"}, bus.det_rst_n, 0);
        chk({tag, "_async_data"}, bus.det_data, 3'b111);
        @(posedge clk);
        #3 reset = 0;
        early = 1;
        break;
      end
      step();
      r++;
    end
    bus.abort = 0; bus.start = 0; bus.sym_valid = 0;
    if (!early && bus.busy) chk({tag, "_session_end_timeout"}, 1, 0);
    chk({tag, "_hits"}, bus.hit_count, e_hits);
    chk({tag, "_timed_out"}, bus.timed_out, e_to);
    chk({tag, "_limit"}, bus.limit_reached, e_lr);
    chk({tag, "_run_cycles"}, run_total - r0, e_runs);
    chk({tag, "_done_pulses"}, done_total - d0, e_done);
    step();
  endtask

  initial begin
    int ridx;
    ridx = 0;
    reset = 1;
    bus.start = 0; bus.abort = 0; bus.window_len = 0; bus.hit_limit = 0;
    bus.sym_in = 0; bus.sym_valid = 0;
    repeat (3) @(posedge clk);
    #3 reset = 0;
    step();

    //        tag    w    l  n   gap ab rst st hits to lr runs done
    session("win20", 20,  0, 8,  0,  0, 0,  3, 1,   1, 0, 20,  1);
    session("lim2",  100, 2, 16, 0,  0, 0,  0, 2,   0, 1, 16,  1);
    session("gap",   20,  0, 8,  4,  0, 0,  0, 0,   1, 0, 20,  1);
    session("win0",  0,   0, 0,  0,  0, 0,  0, 0,   1, 0, 0,   1);
    session("both",  8,   1, 8,  0,  0, 0,  0, 1,   1, 1, 8,   1);
    session("abort5", 20, 0, 8,  0,  5, 0,  3, 0,   0, 0, 5,   0);
    session("abhit", 20,  0, 8,  0,  8, 0,  0, 0,   0, 0, 8,   0);
    session("ab9",   20,  0, 8,  0,  9, 0,  0, 1,   0, 0, 9,   0);
    session("rst5",  20,  0, 8,  0,  0, 5,  0, 0,   0, 0, 4,   0);

    for (int c = 0; c < 4000; c++) begin
      bus.start = ($urandom % 6 == 0);
      bus.abort = ($urandom % 80 == 0);
      bus.window_len = 16'($urandom_range(0, 24));
      bus.hit_limit = 8'($urandom_range(0, 3));
      if ($urandom % 10 < 9) begin
        bus.sym_valid = 1;
        if ($urandom % 20 == 0) bus.sym_in = 3'($urandom);
        else begin
          bus.sym_in = pat(ridx);
          ridx = (ridx + 1) % 8;
        end
      end else bus.sym_valid = 0;
      if ($urandom % 700 == 0) begin
        #1 reset = 1;
        @(posedge clk);
        #3 reset = 0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  session request; sampled in IDLE only.
REQ-004 abort  input  1  terminate session immediately; no effect in IDLE.
REQ-005 window_len  input  16  RUN-cycle budget; latched on accepted start.
REQ-006 hit_limit  input  8  hit count ending the session; 0 = no limit; latched on accepted start.
REQ-007 sym_in  input  3  incoming symbol stream.
REQ-008 sym_valid  input  1  sym_in carries a valid symbol this cycle.
REQ-009 det_found  input  1  sequence_found from the attached 8-symbol detector, combinational on det_data.
REQ-010 det_data  output  3  symbol driven to the detector's data input.
REQ-011 det_rst_n  output  1  active-low reset driven to the detector.
REQ-012 busy  output  1  high in CLEAR, RUN and DONE.
REQ-013 done  output  1  one-cycle pulse at session end (not on abort).
REQ-014 hit_count  output  8  hits counted in the current or last session.
REQ-015 timed_out  output  1  last session ended on window expiry.
REQ-016 limit_reached  output  1  last session ended on hit_limit.

Function
REQ-017 States: IDLE, CLEAR, RUN, DONE; encoding is free.
REQ-018 IDLE: start=1 -> latch window_len/hit_limit, clear hit_count, timed_out, limit_reached -> CLEAR; start=0 -> stay.
REQ-019 CLEAR: exactly one cycle, det_rst_n=0; window counter loaded with latched window_len; -> RUN, or -> DONE with timed_out=1 when window_len=0.
REQ-020 RUN: det_rst_n=1; det_data=sym_in when sym_valid=1, else filler 3'b111, which intentionally breaks any partial sequence.
REQ-021 RUN: window counter decrements every cycle regardless of sym_valid; a RUN cycle whose pre-decrement count is 1 is the last RUN cycle.
REQ-022 RUN: det_found=1 in a cycle increments hit_count at that edge, saturating at 255.
REQ-023 Exit RUN -> DONE when incremented hit_count equals a nonzero hit_limit (set limit_reached) or on the last RUN cycle (set timed_out); if both occur in the same cycle, set both flags.
REQ-024 DONE: done=1 for one cycle, det_rst_n=0, -> IDLE; hit_count and flags held until next accepted start.
REQ-025 det_rst_n=0 and det_data=3'b111 in every state other than RUN.
REQ-026 Latency: start accepted at edge t -> CLEAR during cycle t+1, first RUN cycle t+2, first sym_in forwarded in cycle t+2.
REQ-027 start in any non-IDLE state is ignored; no queueing.
REQ-028 abort=1 in CLEAR/RUN/DONE -> IDLE at next edge, no done pulse, hit_count retained, flags cleared; abort has priority over all other transitions, including a simultaneous hit (hit not counted).
REQ-029 det_found outside RUN is ignored.
REQ-030 Window counter is 16 bits; no wrap, since RUN is left before the count reaches 0.

Reset
REQ-031 reset=1 asynchronously forces IDLE, hit_count=0, timed_out=0, limit_reached=0, done=0, busy=0, det_rst_n=0, det_data=3'b111, window counter=0.
REQ-032 reset mid-session abandons it without a done pulse; first start after release behaves as REQ-018.

Verification
REQ-033 start, window_len=20, hit_limit=0, sequence 001,101,110,000,110,110,011,101 contiguous from first RUN cycle -> hit_count=1, exactly 20 RUN cycles, done pulse, timed_out=1, limit_reached=0.
REQ-034 window_len=100, hit_limit=2, sequence sent twice back-to-back -> DONE after the 16th symbol, hit_count=2, limit_reached=1, timed_out=0.
REQ-035 same sequence with sym_valid=0 for one cycle after the 4th symbol -> hit_count=0, det_data=3'b111 in the gap cycle.
REQ-036 window_len=0 -> CLEAR then DONE, no RUN cycle, hit_count=0, timed_out=1; window_len=8, hit_limit=1, sequence completing on the 8th RUN cycle -> both flags set.
REQ-037 abort in RUN cycle 5, and separately reset in RUN cycle 5 -> IDLE next edge (async for reset), no done pulse, det_rst_n=0; a start issued while busy has no effect.
